// File: rtl/transmitter_unit.sv
// transmitter_unit: UART transmit stage with a one-entry holding register.
// Frames start/data/parity/stop bits on the shared 16x oversample tick.
module transmitter_unit #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic [4:0]        config_reg,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              tx,
  output logic              busy,
  output logic              tx_done
);

  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP1, STOP2
  } state_t;

  state_t            state;
  state_t            state_d;
  logic [TW-1:0]     tick_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shift_d;
  logic [DATA_W-1:0] hold_q;
  logic              hold_full;
  logic              par_en;
  logic              par_bit;
  logic              stop2;
  logic              bit_end;
  logic              last_data;
  logic              frame_end;
  logic              load;
  logic              accept;
  logic              tx_d;
  logic              tx_done_d;
  logic              unused_baud;

  assign unused_baud = ^config_reg[1:0];

  assign bit_end   = tick && (tick_cnt == TICK_LAST)
                     && (state != IDLE);
  assign last_data = (bit_cnt == BIT_LAST);
  assign frame_end = bit_end && ((state == STOP2)
                     || (state == STOP1 && !stop2));
  assign load      = hold_full
                     && ((state == IDLE) || frame_end);
  assign accept    = data_valid && !hold_full;

  assign data_ready = !hold_full;
  assign busy       = (state != IDLE);

  // state plus the registered line outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      tx      <= 1'b1;
      tx_done <= 1'b0;
    end else begin
      state   <= state_d;
      tx      <= tx_d;
      tx_done <= tx_done_d;
    end
  end

  // frame sequencing, advancing on bit boundaries
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (hold_full) state_d = START;
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end && last_data)
          state_d = par_en ? PARITY : STOP1;
      end
      PARITY: begin
        if (bit_end) state_d = STOP1;
      end
      STOP1: begin
        if (bit_end) begin
          if (stop2)          state_d = STOP2;
          else if (hold_full) state_d = START;
          else                state_d = IDLE;
        end
      end
      STOP2: begin
        if (bit_end)
          state_d = hold_full ? START : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // line level for the state being entered
  always_comb begin
    tx_d      = 1'b1;
    tx_done_d = frame_end;
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_bit;
      default: tx_d = 1'b1;
    endcase
  end

  // next shift contents: load a new byte or shift a data bit out
  always_comb begin
    shift_d = shift_q;
    if (load)
      shift_d = hold_q;
    else if (state == DATA && bit_end)
      shift_d = shift_q >> 1;
  end

  // bit timing counters and per-frame config snapshot
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift_q  <= '0;
      par_en   <= 1'b0;
      par_bit  <= 1'b0;
      stop2    <= 1'b0;
    end else begin
      shift_q <= shift_d;
      if (load) begin
        tick_cnt <= '0;
        bit_cnt  <= '0;
        par_en   <= ^config_reg[3:2];
        par_bit  <= (^hold_q) ^ config_reg[3];
        stop2    <= config_reg[4];
      end else if (busy && tick) begin
        tick_cnt <= bit_end ? '0 : tick_cnt + TW'(1);
        if (state == DATA && bit_end)
          bit_cnt <= last_data ? '0 : bit_cnt + BW'(1);
      end
    end
  end

  // holding register: host fills it, frame start drains it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_full <= 1'b0;
      hold_q    <= '0;
    end else if (accept) begin
      hold_full <= 1'b1;
      hold_q    <= data_in;
    end else if (load) begin
      hold_full <= 1'b0;
    end
  end

endmodule
